// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one request at a time to instruction
// memory and hands each returned word to decode; supports redirects and ebreak halt.
module ifu_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [63:0] imem_addr_o,
   input  logic        imem_resp_valid_i,
   input  logic [31:0] imem_resp_data_i,
   output logic [31:0] inst_o,
   output logic [63:0] inst_addr_o,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   input  logic        jump_en_i,
   input  logic [63:0] jump_addr_i,
   input  logic        break_en_i,
   output logic        halted_o
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

   state_t      state;
   logic [63:0] pc;
   logic        squash;
   logic [63:0] jump_tgt;
   logic        req_fire;

   assign jump_tgt    = jump_addr_i & ~64'h3;
   assign req_fire    = imem_req_valid_o && imem_req_ready_i;
   assign imem_addr_o = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_REQ;
         pc               <= RESET_PC;
         squash           <= 1'b0;
         imem_req_valid_o <= 1'b0;
         inst_valid_o     <= 1'b0;
         inst_o           <= NOP_INST;
         inst_addr_o      <= '0;
         halted_o         <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               // valid is low in the first REQ cycle after reset, so it rises here
               imem_req_valid_o <= 1'b1;
               if (jump_en_i) pc <= jump_tgt;
               if (req_fire) begin
                  state            <= S_WAIT;
                  imem_req_valid_o <= 1'b0;
                  squash           <= jump_en_i;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid_i) begin
                  if (squash || jump_en_i) begin
                     squash           <= 1'b0;
                     state            <= S_REQ;
                     imem_req_valid_o <= 1'b1;
                  end else begin
                     inst_o       <= imem_resp_data_i;
                     inst_addr_o  <= pc;
                     inst_valid_o <= 1'b1;
                     state        <= S_HOLD;
                  end
                  if (jump_en_i) pc <= jump_tgt;
               end else if (jump_en_i) begin
                  squash <= 1'b1;
                  pc     <= jump_tgt;
               end
            end
            S_HOLD: begin
               if (break_en_i && inst_valid_o) begin
                  state        <= S_HALT;
                  inst_valid_o <= 1'b0;
                  inst_o       <= NOP_INST;
                  halted_o     <= 1'b1;
               end else if (jump_en_i || inst_ready_i) begin
                  // a redirect drops the held word instead of advancing past it
                  inst_valid_o     <= 1'b0;
                  inst_o           <= NOP_INST;
                  state            <= S_REQ;
                  imem_req_valid_o <= 1'b1;
                  pc               <= jump_en_i ? jump_tgt : pc + 64'd4;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: event-level reference model checked every cycle,
// plus literal expectations for the fetch addresses of each scenario.
module tb_ifu_fetch;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBRK   = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid_o, imem_req_ready_i;
   logic [63:0] imem_addr_o;
   logic        imem_resp_valid_i;
   logic [31:0] imem_resp_data_i;
   logic [31:0] inst_o;
   logic [63:0] inst_addr_o;
   logic        inst_valid_o, inst_ready_i;
   logic        jump_en_i;
   logic [63:0] jump_addr_i;
   logic        break_en_i, halted_o;

   logic        dec_en;
   logic [63:0] ebrk_addr;
   int          lat;
   int          total = 0;
   int          bad = 0;

   ifu_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
      .imem_addr_o(imem_addr_o),
      .imem_resp_valid_i(imem_resp_valid_i), .imem_resp_data_i(imem_resp_data_i),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o),
      .inst_ready_i(inst_ready_i),
      .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
      .break_en_i(break_en_i), .halted_o(halted_o)
   );

   always #5 clk = ~clk;

   // decode flags ebreak when it sees the ebreak encoding
   assign break_en_i = dec_en && inst_valid_o && (inst_o == EBRK);

   function automatic logic [31:0] memw(input logic [63:0] a);
      return (a == ebrk_addr) ? EBRK : (a[31:0] ^ 32'h3c3c_0000);
   endfunction

   // memory: responds lat cycles after acceptance; logs every accepted address
   logic        n_acc;
   logic [63:0] n_addr, pa;
   int          cnt = 0;
   int          hs_cnt = 0;
   logic [63:0] acc_log[$];

   always @(negedge clk) begin
      n_acc  = imem_req_valid_o && imem_req_ready_i;
      n_addr = imem_addr_o;
      if (inst_valid_o && inst_ready_i) hs_cnt++;
   end

   always @(posedge clk) begin
      #1;
      if (n_acc) begin
         pa  = n_addr;
         cnt = lat;
         acc_log.push_back(n_addr);
      end else if (cnt > 0) cnt--;
      imem_resp_valid_i = (cnt == 1);
      imem_resp_data_i  = (cnt == 1) ? memw(pa) : 32'hdead_beef;
   end

   // reference model: outstanding-request / held-word bookkeeping
   logic [63:0] m_pc, e_addr;
   logic        m_pend, m_stale, e_req, e_valid, e_halt;
   logic [31:0] e_inst;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = RST_PC; m_pend = 1'b0; m_stale = 1'b0;
         e_req = 1'b0; e_valid = 1'b0; e_halt = 1'b0; e_inst = NOP; e_addr = '0;
      end else if (!e_halt) begin : mstep
         logic [63:0] tgt;
         logic        fire, got, held;
         tgt  = (jump_addr_i >> 2) << 2;
         held = e_valid;
         fire = e_req && imem_req_ready_i;
         got  = m_pend && imem_resp_valid_i;
         if (held && dec_en && e_inst == EBRK) begin
            e_halt = 1'b1; e_valid = 1'b0; e_inst = NOP; e_req = 1'b0;
         end else begin
            if (got) begin
               m_pend = 1'b0;
               if (!m_stale && !jump_en_i) begin
                  e_valid = 1'b1; e_inst = imem_resp_data_i; e_addr = m_pc;
               end
               m_stale = 1'b0;
            end
            if (fire) begin
               m_pend = 1'b1; m_stale = jump_en_i;
            end else if (m_pend && jump_en_i) m_stale = 1'b1;
            if (held && (jump_en_i || inst_ready_i)) begin
               e_valid = 1'b0; e_inst = NOP;
               if (!jump_en_i) m_pc = m_pc + 64'd4;
            end
            if (jump_en_i) m_pc = tgt;
            e_req = !m_pend && !e_valid;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // every cycle: compare against the model at the falling edge, then move past the next rise
   task automatic step();
      @(negedge clk);
      chk("req_valid", imem_req_valid_o, e_req);
      chk("imem_addr", imem_addr_o, m_pc);
      chk("inst_valid", inst_valid_o, e_valid);
      chk("inst", inst_o, e_inst);
      chk("inst_addr", inst_addr_o, e_addr);
      chk("halted", halted_o, e_halt);
      @(posedge clk);
      #2;
   endtask

   // kind: 0 inst held, 1 waiting on memory, 2 halted, 3 new accepted request
   task automatic wait_st(input int kind, input int base, input string name);
      bit ok;
      for (int n = 0; n <= 50; n++) begin
         case (kind)
            0: ok = inst_valid_o;
            1: ok = !imem_req_valid_o && !inst_valid_o && !halted_o;
            2: ok = halted_o;
            default: ok = acc_log.size() > base;
         endcase
         if (ok) return;
         if (n == 50) begin
            total++; bad++;
            $display("FAIL timeout %s: got none expected event", name);
            return;
         end
         step();
      end
   endtask

   initial begin
      int base, hs0;
      logic [63:0] ha;
      logic [31:0] hd;
      imem_req_ready_i = 1'b1; inst_ready_i = 1'b1;
      jump_en_i = 1'b0; jump_addr_i = '0;
      dec_en = 1'b0; ebrk_addr = '0; lat = 1;
      step();
      chk("rst_req_valid", imem_req_valid_o, 0);
      chk("rst_inst", inst_o, NOP);
      chk("rst_addr", imem_addr_o, RST_PC);
      step();
      rst_n = 1'b1;

      // 1: straight-line fetch, one word per three cycles
      repeat (12) step();
      if (acc_log.size() >= 3) begin
         chk("t1_addr0", acc_log[0], 64'h8000_0000);
         chk("t1_addr1", acc_log[1], 64'h8000_0004);
         chk("t1_addr2", acc_log[2], 64'h8000_0008);
      end else chk("t1_count", acc_log.size(), 3);
      hs0 = hs_cnt;
      repeat (9) step();
      chk("t1_rate", hs_cnt - hs0, 3);

      // 2: decode stalls for five cycles
      inst_ready_i = 1'b0;
      wait_st(0, 0, "t2_valid");
      ha = inst_addr_o; hd = inst_o; base = acc_log.size();
      repeat (5) begin
         step();
         chk("t2_addr_hold", inst_addr_o, ha);
         chk("t2_inst_hold", inst_o, hd);
         chk("t2_no_req", imem_req_valid_o, 0);
      end
      chk("t2_no_acc", acc_log.size(), base);
      inst_ready_i = 1'b1;
      step();
      chk("t2_advance", imem_addr_o, ha + 64'd4);

      // 3: redirect while waiting; in-flight word is squashed
      lat = 3;
      step();
      wait_st(1, 0, "t3_wait");
      jump_en_i = 1'b1; jump_addr_i = 64'h8000_0103;
      step();
      jump_en_i = 1'b0; lat = 1;
      base = acc_log.size();
      wait_st(3, base, "t3_acc");
      if (acc_log.size() > base) chk("t3_target", acc_log[base], 64'h8000_0100);

      // 4: redirect beats the decode handshake in HOLD
      wait_st(0, 0, "t4_valid");
      jump_en_i = 1'b1; jump_addr_i = 64'h8000_0200;
      step();
      jump_en_i = 1'b0;
      chk("t4_drop", inst_valid_o, 0);
      chk("t4_pc", imem_addr_o, 64'h8000_0200);
      base = acc_log.size();
      wait_st(3, base, "t4_acc");
      if (acc_log.size() > base) chk("t4_target", acc_log[base], 64'h8000_0200);

      // 5: ebreak halts; jumps ignored; reset pulse restarts
      ebrk_addr = 64'h8000_0204; dec_en = 1'b1;
      wait_st(2, 0, "t5_halt");
      chk("t5_halt_inst", inst_o, NOP);
      chk("t5_halt_pc", imem_addr_o, 64'h8000_0204);
      base = acc_log.size();
      jump_en_i = 1'b1; jump_addr_i = 64'h0000_0000_0000_0040;
      step();
      jump_en_i = 1'b0;
      repeat (4) step();
      chk("t5_no_acc", acc_log.size(), base);
      chk("t5_jump_ignored", imem_addr_o, 64'h8000_0204);
      chk("t5_still_halted", halted_o, 1);
      rst_n = 1'b0; dec_en = 1'b0;
      #1;
      chk("t5_rst_pc", imem_addr_o, RST_PC);
      chk("t5_rst_halted", halted_o, 0);
      rst_n = 1'b1;
      base = acc_log.size();
      wait_st(3, base, "t5_acc");
      if (acc_log.size() > base) chk("t5_restart", acc_log[base], RST_PC);

      // 6: reset during WAIT; stale response lands in REQ and is ignored
      lat = 2;
      repeat (4) step();
      wait_st(1, 0, "t6_wait");
      imem_req_ready_i = 1'b0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      base = acc_log.size();
      repeat (4) step();
      chk("t6_no_inst", inst_valid_o, 0);
      chk("t6_no_acc", acc_log.size(), base);
      imem_req_ready_i = 1'b1; lat = 1;
      wait_st(3, base, "t6_acc");
      if (acc_log.size() > base) chk("t6_first", acc_log[base], RST_PC);
      repeat (10) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
